// File: rtl/mux_scan_controller.sv
// rtl/mux_scan_controller.sv - steps a 4-to-1 mux select through all channels,
// samples each after DWELL cycles and hands the 4-bit word over with VALID/ACK.
module mux_scan_controller #(
   parameter int DWELL = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       cont,
   input  logic       abort,
   input  logic       mux_out,
   output logic       s0,
   output logic       s1,
   output logic       busy,
   output logic [3:0] data,
   output logic       valid,
   input  logic       ack,
   output logic       overrun
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t        state, state_n;
   logic [1:0]    chan, chan_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    shadow, shadow_n;
   logic [3:0]    data_n;
   logic          valid_n, overrun_n;

   assign s1   = chan[1];
   assign s0   = chan[0];
   assign busy = (state == SCAN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         chan    <= 2'd0;
         cnt     <= '0;
         shadow  <= 3'd0;
         data    <= 4'd0;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= state_n;
         chan    <= chan_n;
         cnt     <= cnt_n;
         shadow  <= shadow_n;
         data    <= data_n;
         valid   <= valid_n;
         overrun <= overrun_n;
      end
   end

   always_comb begin
      state_n   = state;
      chan_n    = chan;
      cnt_n     = cnt;
      shadow_n  = shadow;
      data_n    = data;
      valid_n   = valid;
      overrun_n = overrun;

      // An accept is overridden below if a fresh word lands on the same edge.
      if (valid && ack) valid_n = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_n   = SCAN;
               chan_n    = 2'd0;
               cnt_n     = '0;
               shadow_n  = 3'd0;
               overrun_n = 1'b0;
            end
         end
         SCAN: begin
            if (abort) begin
               state_n  = IDLE;
               chan_n   = 2'd0;
               cnt_n    = '0;
               shadow_n = 3'd0;
            end else if (cnt == LAST) begin
               cnt_n  = '0;
               chan_n = chan + 2'd1;
               case (chan)
                  2'd0: shadow_n[0] = mux_out;
                  2'd1: shadow_n[1] = mux_out;
                  2'd2: shadow_n[2] = mux_out;
                  default: begin
                     data_n   = {mux_out, shadow};
                     valid_n  = 1'b1;
                     shadow_n = 3'd0;
                     if (valid && !ack) overrun_n = 1'b1;
                     if (!cont) state_n = IDLE;
                  end
               endcase
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mux_scan_controller.sv
// tb/tb_mux_scan_controller.sv - bench for mux_scan_controller; three instances
// with DWELL 4, 1 and 2 each drive their own model of the 4-to-1 mux.
module tb_mux_scan_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, cont = 1'b0, abort = 1'b0, ack = 1'b0;
   logic [3:0] abcd = 4'd0;
   logic [2:0] s0_o, s1_o, busy_o, valid_o, overrun_o, mux_o;
   logic [3:0] data_o [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int DW = (g == 0) ? 4 : ((g == 1) ? 1 : 2);
      mux_scan_controller #(.DWELL(DW)) u_dut (
         .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
         .mux_out(mux_o[g]), .s0(s0_o[g]), .s1(s1_o[g]), .busy(busy_o[g]),
         .data(data_o[g]), .valid(valid_o[g]), .ack(ack), .overrun(overrun_o[g])
      );
      assign mux_o[g] = abcd[{s1_o[g], s0_o[g]}];
   end

   // {busy, s1, s0, valid, overrun, data}
   function automatic logic [8:0] st(int i);
      return {busy_o[i], s1_o[i], s0_o[i], valid_o[i], overrun_o[i], data_o[i]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start = 0; cont = 0; abort = 0; ack = 0;
      rst_n = 0;
      tick(); tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_reset();
      logic [8:0] s;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         s = st(i);
         if (s !== 9'd0) begin errors++; $display("FAIL reset_state[%0d] got=%b exp=%b", i, s, 9'd0); end
         checks++;
      end
   endtask

   task automatic test_single_scan();
      logic [8:0] s;
      logic [2:0] exp3;
      do_reset();
      for (int it = 0; it < 6; it++) begin
         abcd = (it == 0) ? 4'b1010 : 4'($urandom);
         start = 1; tick(); start = 0;
         for (int t = 0; t < 16; t++) begin
            s = st(0);
            exp3 = {1'b1, 2'(t / 4)};
            if ({s[8:6], s[5]} !== {exp3, 1'b0}) begin
               errors++; $display("FAIL single_step it=%0d t=%0d got=%b exp=%b", it, t, {s[8:6], s[5]}, {exp3, 1'b0});
            end
            checks++;
            start = 1'($urandom_range(0, 1));
            tick();
         end
         start = 0;
         s = st(0);
         if (s !== {5'b00010, abcd}) begin errors++; $display("FAIL single_done got=%b exp=%b", s, {5'b00010, abcd}); end
         checks++;
         ack = 1; tick(); ack = 0;
         s = st(0);
         if (s !== {5'b00000, abcd}) begin errors++; $display("FAIL single_ack got=%b exp=%b", s, {5'b00000, abcd}); end
         checks++;
         ack = 1; tick(); ack = 0;
         s = st(0);
         if (s !== {5'b00000, abcd}) begin errors++; $display("FAIL idle_ack got=%b exp=%b", s, {5'b00000, abcd}); end
         checks++;
      end
   endtask

   task automatic test_continuous();
      logic [8:0] s, e;
      logic       mvalid = 0, mover = 0, mbusy;
      logic [3:0] mdata = 0;
      do_reset();
      abcd = 4'b0011;
      cont = 1;
      start = 1; tick(); start = 0;
      for (int w = 0; w < 6; w++) begin
         for (int c = 0; c < 4; c++) begin
            s = st(1);
            if (s[8:6] !== {1'b1, 2'(c)}) begin errors++; $display("FAIL cont_sel w=%0d got=%b exp=%b", w, s[8:6], {1'b1, 2'(c)}); end
            checks++;
            if (c < 3) tick();
         end
         if (w == 5) cont = 0;
         mbusy = cont;
         tick();
         if (mvalid && !ack) mover = 1;
         mvalid = 1;
         mdata = abcd;
         s = st(1);
         e = {mbusy, 2'b00, mvalid, mover, mdata};
         if (s !== e) begin errors++; $display("FAIL cont_word w=%0d got=%b exp=%b", w, s, e); end
         checks++;
         if (w >= 1) abcd = 4'($urandom);
      end
      start = 1; tick(); start = 0;
      s = st(1);
      e = {5'b10010, mdata};
      if (s !== e) begin errors++; $display("FAIL start_clears_overrun got=%b exp=%b", s, e); end
      checks++;
      repeat (4) tick();
      s = st(1);
      e = {5'b00011, abcd};
      if (s !== e) begin errors++; $display("FAIL overrun_again got=%b exp=%b", s, e); end
      checks++;
   endtask

   task automatic test_abort();
      logic [8:0] s, e;
      logic [3:0] w1;
      do_reset();
      abcd = 4'($urandom);
      w1 = abcd;
      start = 1; tick(); start = 0;
      repeat (8) tick();
      s = st(2);
      e = {5'b00010, w1};
      if (s !== e) begin errors++; $display("FAIL abort_first_word got=%b exp=%b", s, e); end
      checks++;
      abcd = ~w1;
      start = 1; tick(); start = 0;
      repeat (7) tick();
      abort = 1; tick(); abort = 0;
      s = st(2);
      if (s !== e) begin errors++; $display("FAIL abort_final got=%b exp=%b", s, e); end
      checks++;
      for (int it = 0; it < 4; it++) begin
         start = 1; tick(); start = 0;
         repeat ($urandom_range(0, 6)) tick();
         abort = 1; tick(); abort = 0;
         s = st(2);
         if (s !== e) begin errors++; $display("FAIL abort_mid it=%0d got=%b exp=%b", it, s, e); end
         checks++;
      end
      abort = 1; tick(); abort = 0;
      s = st(2);
      if (s !== e) begin errors++; $display("FAIL abort_idle got=%b exp=%b", s, e); end
      checks++;
      abort = 1; start = 1; tick(); abort = 0; start = 0;
      s = st(2);
      if (s[8:6] !== 3'b100) begin errors++; $display("FAIL abort_start got=%b exp=%b", s[8:6], 3'b100); end
      checks++;
      repeat (8) tick();
      s = st(2);
      e = {5'b00011, ~w1};
      if (s !== e) begin errors++; $display("FAIL abort_then_scan got=%b exp=%b", s, e); end
      checks++;
   endtask

   task automatic test_ack_completion();
      logic [8:0] s, e;
      logic [3:0] a1, a2, a3, a4;
      do_reset();
      cont = 1;
      a1 = 4'($urandom); a2 = 4'($urandom); a3 = 4'($urandom); a4 = 4'($urandom);
      abcd = a1;
      start = 1; tick(); start = 0;
      repeat (4) tick();
      s = st(1); e = {5'b10010, a1};
      if (s !== e) begin errors++; $display("FAIL ackc_w1 got=%b exp=%b", s, e); end
      checks++;
      abcd = a2;
      ack = 1; tick(); ack = 0;
      s = st(1); e = {5'b10100, a1};
      if (s !== e) begin errors++; $display("FAIL ackc_clear got=%b exp=%b", s, e); end
      checks++;
      repeat (3) tick();
      s = st(1); e = {5'b10010, a2};
      if (s !== e) begin errors++; $display("FAIL ackc_w2 got=%b exp=%b", s, e); end
      checks++;
      abcd = a3;
      repeat (3) tick();
      ack = 1; tick(); ack = 0;
      s = st(1); e = {5'b10010, a3};
      if (s !== e) begin errors++; $display("FAIL ackc_same_edge got=%b exp=%b", s, e); end
      checks++;
      abcd = a4;
      repeat (4) tick();
      s = st(1); e = {5'b10011, a4};
      if (s !== e) begin errors++; $display("FAIL ackc_overrun got=%b exp=%b", s, e); end
      checks++;
   endtask

   task automatic test_async_reset();
      logic [8:0] s;
      do_reset();
      abcd = 4'($urandom) | 4'b0001;
      start = 1; tick(); start = 0;
      repeat (16) tick();
      start = 1; tick(); start = 0;
      repeat (5) tick();
      #2 rst_n = 0;
      #1;
      for (int i = 0; i < 3; i++) begin
         s = st(i);
         if (s !== 9'd0) begin errors++; $display("FAIL async_reset[%0d] got=%b exp=%b", i, s, 9'd0); end
         checks++;
      end
      tick();
      rst_n = 1;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_scan();
      test_continuous();
      test_abort();
      test_ack_completion();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_scan_controller.md
# mux_scan_controller

Sequential front-end that drives the select lines of the 4-to-1 mux and samples its output. It steps S1:S0 through all four channels, holds each for a programmable dwell time, and captures the mux output at the end of each dwell. The four samples are assembled into one 4-bit word for the downstream consumer, with a VALID/ACK handshake and overrun detection.

## Interface

- DWELL, default 4: cycles each channel is held selected, ≥1; sample taken on the last cycle.
- CLK  input  1  single system clock, rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- START  input  1  begin a scan; honoured only in IDLE.
- CONT  input  1  continuous mode; sampled at the end of each scan.
- ABORT  input  1  synchronous abort of an active scan.
- MUX_OUT  input  1  output of the downstream 4-to-1 mux.
- S0  output  1  mux select LSB.
- S1  output  1  mux select MSB.
- BUSY  output  1  high while a scan is in progress.
- DATA  output  4  captured word; bit i = MUX_OUT sampled while {S1,S0}=i.
- VALID  output  1  DATA holds an unconsumed word.
- ACK  input  1  consumer accepts DATA; effective only when VALID=1.
- OVERRUN  output  1  sticky; a word was overwritten before it was acknowledged.

## Operation

- Channel mapping: {S1,S0}=0→A, 1→B, 2→C, 3→D.
- States: IDLE, SCAN.
- IDLE: S1:S0=00, BUSY=0. START=1 → SCAN with channel 0, dwell counter 0, BUSY=1. Clear OVERRUN on the same edge.
- SCAN: the dwell counter counts 0..DWELL-1 per channel.
  - On the edge where dwell==DWELL-1, MUX_OUT is stored into shadow bit [channel], and the channel advances (3 wraps to 0).
  - At the channel 3 sample edge, DATA ← {MUX_OUT, shadow[2:0]} and VALID←1.
  - If VALID was already 1 and ACK=0 on that edge, OVERRUN←1.
  - Then, if CONT=1, the block stays in SCAN at channel 0 with no gap. Otherwise it goes to IDLE with S=00.
- START while in SCAN is ignored.
- ABORT=1 in SCAN → IDLE on the next edge. The partial word is discarded and DATA/VALID are unchanged. ABORT wins over a simultaneous final sample: no DATA update, no VALID. ABORT in IDLE has no effect. ABORT and START in IDLE together: START is honoured.
- Handshake:
  - VALID=1 and ACK=1 → VALID←0, unless a new word completes on the same edge; then VALID stays 1, DATA updates, and OVERRUN is not set.
  - ACK with VALID=0 is ignored.
- Reset (asynchronous, any time including mid-scan): IDLE, S1=S0=0, BUSY=0, DATA=0000, VALID=0, OVERRUN=0, all counters and shadow bits 0.

## Timing

- S1/S0/BUSY are registered and change on the START edge or on channel-advance edges only.
- Channel i is driven for exactly DWELL cycles. MUX_OUT is sampled on the DWELL-th rising edge after S was set, which gives the mux DWELL-1 settle cycles. DWELL=1 means a sample every cycle.
- Latency: START seen at edge k → DATA/VALID update at edge k+4·DWELL → BUSY falls at the same edge (single-shot).
- Continuous mode produces one word every 4·DWELL cycles.
- VALID stays high until ACK; there is no timeout.

## Test plan

- Reset/idle: hold RST_N=0, then release. Required: S=00, DATA=0000, VALID=0, BUSY=0, OVERRUN=0. Assert RST_N=0 mid-scan; all outputs clear immediately, without waiting for a clock edge.
- Single scan, DWELL=4, with A=0, B=1, C=0, D=1:
  - Pulse START. S1:S0 steps 00, 01, 10, 11, four cycles each.
  - DATA=1010 and VALID=1 sixteen cycles after START; BUSY falls on the same edge.
  - An ACK one cycle later clears VALID.
- Continuous scan with OVERRUN, DWELL=1, CONT=1, inputs A=1, B=1, C=0, D=0, never ACK:
  - DATA=0011 is produced every 4 cycles.
  - OVERRUN=1 after the second word.
  - The next START from IDLE clears OVERRUN.
- ABORT at the final sample: DWELL=2, ABORT on the channel 3 sample edge. Required: IDLE, S=00, and VALID/DATA keep their previous values.
- Simultaneous ACK and completion: in CONT mode, assert ACK on the edge a new word lands. Required: VALID stays 1, DATA holds the new word, OVERRUN stays 0.
- Ignored inputs: START while BUSY does not restart the sequence; ACK while VALID=0 has no effect.
